// File: rtl/spi_burst_seq.sv
// rtl/spi_burst_seq.sv - multi-byte burst sequencer feeding an SPI master byte engine
module spi_burst_seq #(
  parameter int FIFO_DEPTH    = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       start,
  input  logic [7:0] len,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       active,
  output logic       done,
  output logic       err,
  output logic [7:0] spi_data_in,
  output logic       spi_ready_send,
  input  logic       spi_busy,
  input  logic [7:0] spi_data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT) + 1;
  localparam logic [PW-1:0] DEPTH_C    = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(FIFO_DEPTH - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_STORE,
    S_FINISH
  } state_e;

  state_e state_q, state_d;

  // TX FIFO storage and pointers
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_push, tx_pop;

  // RX FIFO storage and pointers
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [PW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [PW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_push, rx_pop;

  // Burst bookkeeping and registered outputs
  logic [7:0]    remaining_q, remaining_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic [7:0]    data_in_q, data_in_d;
  logic          send_q, send_d;
  logic          done_q, done_d;
  logic          active_q, active_d;

  logic [7:0]    tx_head;
  logic          tx_empty, rx_full;

  // Pointers only ever hold 0..FIFO_DEPTH-1, so their top bit stays zero
  logic          unused_ptr_msbs;
  assign unused_ptr_msbs = ^{tx_wr_ptr_q[AW], tx_rd_ptr_q[AW], rx_wr_ptr_q[AW], rx_rd_ptr_q[AW]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign tx_ready = (tx_cnt_q != DEPTH_C);
  assign tx_push  = tx_valid && tx_ready;
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_head  = tx_mem_q[tx_rd_ptr_q[AW-1:0]];

  assign rx_valid = (rx_cnt_q != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_full  = (rx_cnt_q == DEPTH_C);
  assign rx_data  = rx_mem_q[rx_rd_ptr_q[AW-1:0]];

  // FIFO pointer and occupancy next-state; push and pop together leave count unchanged
  always_comb begin
    tx_wr_ptr_d = tx_push ? ptr_inc(tx_wr_ptr_q) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? ptr_inc(tx_rd_ptr_q) : tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + PW'(1);
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - PW'(1);
    end
    rx_wr_ptr_d = rx_push ? ptr_inc(rx_wr_ptr_q) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? ptr_inc(rx_rd_ptr_q) : rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + PW'(1);
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - PW'(1);
    end
  end

  // FIFO data arrays; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wr_ptr_q[AW-1:0]] <= tx_data;
    end
    if (rx_push) begin
      rx_mem_q[rx_wr_ptr_q[AW-1:0]] <= spi_data_out;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decisions for the burst sequencer
  always_comb begin
    state_d     = state_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    err_d       = err_q;
    data_in_d   = data_in_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (len != 8'd0) begin
            remaining_d = len;
            state_d     = S_LOAD;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_LOAD: begin
        // Only one byte is ever in flight, so reserving an RX slot here is enough
        if (!tx_empty && !rx_full && !spi_busy) begin
          data_in_d = tx_head;
          tx_pop    = 1'b1;
          state_d   = S_KICK;
        end
      end
      S_KICK: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (spi_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
          if (timer_d == TIMER_LAST) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!spi_busy) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        rx_push     = 1'b1;
        remaining_d = remaining_q - 8'd1;
        state_d     = (remaining_q == 8'd1) ? S_FINISH : S_LOAD;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs align with it
  always_comb begin
    send_d   = (state_d == S_KICK);
    done_d   = (state_d == S_FINISH);
    active_d = (state_d != S_IDLE);
  end

  // Datapath, FIFO bookkeeping and registered output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      remaining_q <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      data_in_q   <= '0;
      send_q      <= 1'b0;
      done_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      data_in_q   <= data_in_d;
      send_q      <= send_d;
      done_q      <= done_d;
      active_q    <= active_d;
    end
  end

  assign spi_data_in    = data_in_q;
  assign spi_ready_send = send_q;
  assign done           = done_q;
  assign active         = active_q;
  assign err            = err_q;

endmodule

// File: tb/tb_spi_burst_seq.sv
// tb/tb_spi_burst_seq.sv - directed self-checking bench for spi_burst_seq
module tb_spi_burst_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       start = 1'b0;
  logic [7:0] len = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       active;
  logic       done;
  logic       err;
  logic [7:0] spi_data_in;
  logic       spi_ready_send;
  logic       spi_busy = 1'b0;
  logic [7:0] spi_data_out = 8'h00;

  spi_burst_seq #(.FIFO_DEPTH(8), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .start(start), .len(len),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .active(active), .done(done), .err(err),
    .spi_data_in(spi_data_in), .spi_ready_send(spi_ready_send),
    .spi_busy(spi_busy), .spi_data_out(spi_data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor plus engine model: busy rises 2 cycles after the strobe, holds 16
  int strobe_cnt = 0, done_cnt = 0, strobe_cyc = 0, done_cyc = 0, err_cyc = -1, since = -1;
  logic err_prev = 1'b0;
  logic model_on = 1'b1;
  logic [7:0] strobe_log [64];
  always @(negedge clk) begin
    if (spi_ready_send) begin
      strobe_log[strobe_cnt[5:0]] = spi_data_in;
      strobe_cnt++;
      strobe_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err && !err_prev) err_cyc = cyc;
    err_prev = err;
    if (spi_ready_send && model_on) since = 0;
    else if (since >= 0) since++;
    if (since >= 2 && since < 18) begin
      spi_busy = 1'b1;
      spi_data_out = ~spi_data_in;
    end else begin
      spi_busy = 1'b0;
    end
    if (since >= 18) since = -1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int t = 0;
    tx_valid = 1'b1;
    tx_data = b;
    while (!tx_ready && t < 100) begin
      tick();
      t++;
    end
    tick();
    tx_valid = 1'b0;
    if (t >= 100) chk("push_timeout", 32'(t), 0);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    rx_ready = 1'b1;
    chk({tag, "_valid"}, 32'(rx_valid), 1);
    chk(tag, 32'(rx_data), 32'(exp));
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic start_burst(input logic [7:0] n);
    start = 1'b1;
    len = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int d0 = done_cnt;
    int t = 0;
    while (done_cnt == d0 && t < max) begin
      tick();
      t++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
  endtask

  initial begin
    int s0, d0, pushed, t;
    logic hs;

    // 1: reset state
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst_active", 32'(active), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_send", 32'(spi_ready_send), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_data_in", 32'(spi_data_in), 0);

    // 2: basic three-byte burst
    push(8'hA5); push(8'h3C); push(8'hFF);
    s0 = strobe_cnt; d0 = done_cnt;
    start_burst(8'd3);
    chk("t2_active", 32'(active), 1);
    wait_done("t2", 500);
    chk("t2_strobes", 32'(strobe_cnt - s0), 3);
    chk("t2_byte0", 32'(strobe_log[s0[5:0]]), 32'hA5);
    chk("t2_byte1", 32'(strobe_log[6'(s0 + 1)]), 32'h3C);
    chk("t2_byte2", 32'(strobe_log[6'(s0 + 2)]), 32'hFF);
    chk("t2_done_once", 32'(done_cnt - d0), 1);
    chk("t2_err", 32'(err), 0);
    chk("t2_active_off", 32'(active), 0);
    chk("t2_tx_cnt", 32'(dut.tx_cnt_q), 0);
    pop_chk("t2_rx0", 8'h5A);
    pop_chk("t2_rx1", 8'hC3);
    pop_chk("t2_rx2", 8'h00);
    chk("t2_rx_empty", 32'(rx_valid), 0);

    // 3: TX underrun stalls in LOAD until more bytes arrive
    push(8'h01); push(8'h02);
    s0 = strobe_cnt; d0 = done_cnt;
    start_burst(8'd4);
    repeat (120) tick();
    chk("t3_strobes2", 32'(strobe_cnt - s0), 2);
    chk("t3_stall_active", 32'(active), 1);
    repeat (50) tick();
    chk("t3_no_strobe", 32'(strobe_cnt - s0), 2);
    chk("t3_no_done", 32'(done_cnt - d0), 0);
    push(8'h03); push(8'h04);
    wait_done("t3", 300);
    chk("t3_strobes4", 32'(strobe_cnt - s0), 4);
    pop_chk("t3_rx0", 8'hFE);
    pop_chk("t3_rx1", 8'hFD);
    pop_chk("t3_rx2", 8'hFC);
    pop_chk("t3_rx3", 8'hFB);

    // 4: RX full back-pressure with a 10-byte burst
    s0 = strobe_cnt; d0 = done_cnt; pushed = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == 0) begin
        start = 1'b1;
        len = 8'd10;
      end else begin
        start = 1'b0;
      end
      if (pushed < 10 && tx_ready) begin
        tx_valid = 1'b1;
        tx_data = 8'(8'h10 + pushed);
      end else begin
        tx_valid = 1'b0;
      end
      hs = tx_valid;
      tick();
      if (hs) pushed++;
    end
    tx_valid = 1'b0;
    start = 1'b0;
    chk("t4_pushed", 32'(pushed), 10);
    chk("t4_strobes8", 32'(strobe_cnt - s0), 8);
    chk("t4_no_done", 32'(done_cnt - d0), 0);
    chk("t4_active", 32'(active), 1);
    chk("t4_rx_full", 32'(dut.rx_cnt_q), 8);
    pop_chk("t4_pop0", 8'hEF);
    pop_chk("t4_pop1", 8'hEE);
    wait_done("t4", 200);
    chk("t4_strobes10", 32'(strobe_cnt - s0), 10);
    chk("t4_rx_cnt_end", 32'(dut.rx_cnt_q), 8);
    for (int i = 0; i < 8; i++) pop_chk("t4_drain", ~(8'(8'h12 + i)));
    chk("t4_rx_empty", 32'(rx_valid), 0);

    // 5: engine never responds -> start timeout
    model_on = 1'b0;
    push(8'h11); push(8'h22);
    s0 = strobe_cnt; d0 = done_cnt;
    start_burst(8'd2);
    wait_done("t5", 100);
    chk("t5_strobes", 32'(strobe_cnt - s0), 1);
    chk("t5_strobe_byte", 32'(strobe_log[s0[5:0]]), 32'h11);
    chk("t5_err", 32'(err), 1);
    chk("t5_err_latency", 32'(err_cyc - strobe_cyc), 16);
    chk("t5_done_with_err", 32'(done_cyc - strobe_cyc), 16);
    chk("t5_done_once", 32'(done_cnt - d0), 1);
    chk("t5_tx_cnt", 32'(dut.tx_cnt_q), 1);
    repeat (3) tick();
    chk("t5_err_sticky", 32'(err), 1);
    model_on = 1'b1;
    start_burst(8'd1);
    chk("t5_err_cleared", 32'(err), 0);
    wait_done("t5b", 100);
    pop_chk("t5_rx", 8'hDD);

    // 6a: empty burst
    s0 = strobe_cnt; d0 = done_cnt;
    start_burst(8'd0);
    chk("t6a_done", 32'(done), 1);
    chk("t6a_active", 32'(active), 1);
    tick();
    chk("t6a_done_off", 32'(done), 0);
    chk("t6a_active_off", 32'(active), 0);
    chk("t6a_done_once", 32'(done_cnt - d0), 1);
    chk("t6a_no_strobe", 32'(strobe_cnt - s0), 0);

    // 6b: start pulsed mid-burst is ignored
    push(8'h5C); push(8'h77);
    s0 = strobe_cnt; d0 = done_cnt;
    start_burst(8'd1);
    t = 0;
    while (strobe_cnt == s0 && t < 50) begin
      tick();
      t++;
    end
    start_burst(8'd5);
    wait_done("t6b", 100);
    repeat (40) tick();
    chk("t6b_strobes", 32'(strobe_cnt - s0), 1);
    chk("t6b_done_once", 32'(done_cnt - d0), 1);
    chk("t6b_active", 32'(active), 0);
    chk("t6b_tx_cnt", 32'(dut.tx_cnt_q), 1);
    pop_chk("t6b_rx", 8'hA3);

    // 6c: reset while waiting for the engine to finish
    d0 = done_cnt;
    start_burst(8'd1);
    t = 0;
    while (!spi_busy && t < 20) begin
      tick();
      t++;
    end
    chk("t6c_busy_seen", 32'(spi_busy), 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6c_active", 32'(active), 0);
    chk("t6c_done", 32'(done), 0);
    chk("t6c_send", 32'(spi_ready_send), 0);
    chk("t6c_data_in", 32'(spi_data_in), 0);
    chk("t6c_rx_valid", 32'(rx_valid), 0);
    chk("t6c_tx_ready", 32'(tx_ready), 1);
    chk("t6c_tx_cnt", 32'(dut.tx_cnt_q), 0);
    repeat (30) tick();
    chk("t6c_no_done", 32'(done_cnt - d0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
